// File: rtl/alt_isqrt_pkg.sv
// Shared types and helpers for the iterative integer square-root unit.
package alt_isqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Root width: one root bit per radicand bit pair.
  function automatic int q_of(input int data_width);
    return (data_width + 1) / 2;
  endfunction

endpackage

// File: rtl/alt_isqrt_step.sv
// One restoring square-root digit: brings down two radicand bits and
// decides the next root bit by trial subtraction.
module alt_isqrt_step #(
  parameter int Q = 8
) (
  input  logic [Q+1:0] rem_i,
  input  logic [1:0]   bits_i,
  input  logic [Q-1:0] root_i,
  output logic [Q+1:0] rem_o,
  output logic [Q-1:0] root_o
);

  logic [Q+1:0] r_sh;
  logic [Q+1:0] trial;
  logic         ge;
  logic         unused_rem_msb;

  // Top two rem bits fall off; they are zero whenever the step is reached.
  assign unused_rem_msb = &{1'b0, rem_i[Q+1:Q]};
  assign r_sh  = {rem_i[Q-1:0], bits_i};
  assign trial = {root_i, 2'b01};
  assign ge    = (r_sh >= trial);

  always_comb begin
    rem_o     = ge ? (r_sh - trial) : r_sh;
    root_o    = root_i << 1;
    root_o[0] = ge;
  end

endmodule

// File: rtl/alt_isqrt.sv
// Iterative integer square root: one root bit per enabled clock, with
// valid/ready handshakes on both the radicand and the result side.
module alt_isqrt
  import alt_isqrt_pkg::*;
#(
  parameter int data_width     = 16,
  parameter     representation = "UNSIGNED",
  parameter     lpm_type       = "alt_isqrt"
) (
  input  logic                            clock,
  input  logic                            aclr_n,
  input  logic                            ena,
  input  logic [data_width-1:0]           data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [q_of(data_width)-1:0]     root,
  output logic [q_of(data_width):0]       remainder,
  output logic                            neg,
  output logic                            out_valid,
  input  logic                            out_ready
);

  localparam int Q         = q_of(data_width);
  localparam int CW        = (Q > 1) ? $clog2(Q) : 1;
  localparam bit IS_SIGNED = (representation == "SIGNED");

  if (data_width < 1) begin : g_bad_width
    $fatal(1, "alt_isqrt: data_width must be at least 1");
  end

  state_e          state_q, state_d;
  logic [2*Q-1:0]  mag_q, mag_ld;
  logic [Q+1:0]    rem_q, rem_nx;
  logic [Q-1:0]    root_q, root_nx;
  logic [CW-1:0]   cnt_q;
  logic            neg_q, neg_ld;
  logic            accept;

  assign accept = in_valid & in_ready;
  assign neg_ld = IS_SIGNED & data[data_width-1];

  // Two's-complement negate at full data width so the most negative value
  // becomes 2^(data_width-1) after zero extension.
  always_comb begin
    logic [data_width-1:0] abs_v;
    abs_v  = neg_ld ? (~data + 1'b1) : data;
    mag_ld = '0;
    mag_ld[data_width-1:0] = abs_v;
  end

  alt_isqrt_step #(.Q(Q)) u_step (
    .rem_i  (rem_q),
    .bits_i (mag_q[2*Q-1 -: 2]),
    .root_i (root_q),
    .rem_o  (rem_nx),
    .root_o (root_nx)
  );

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)                    state_d = BUSY;
      BUSY:    if (ena && (cnt_q == '0))      state_d = DONE;
      DONE:    if (out_ready && ena)          state_d = IDLE;
      default:                                state_d = IDLE;
    endcase
  end

  // in_ready is gated by aclr_n so it drops the moment reset is asserted.
  always_comb begin
    in_ready  = (state_q == IDLE) & ena & aclr_n;
    out_valid = (state_q == DONE);
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      mag_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
    end else if (ena) begin
      if (accept) begin
        mag_q  <= mag_ld;
        rem_q  <= '0;
        root_q <= '0;
        cnt_q  <= CW'(Q - 1);
        neg_q  <= neg_ld;
      end else if (state_q == BUSY) begin
        mag_q  <= mag_q << 2;
        rem_q  <= rem_nx;
        root_q <= root_nx;
        cnt_q  <= cnt_q - CW'(1);
      end
    end
  end

  logic unused_rem_top;
  assign unused_rem_top = &{1'b0, rem_q[Q+1]};

  assign root      = root_q;
  assign remainder = rem_q[Q:0];
  assign neg       = neg_q;

endmodule

// File: tb/tb_alt_isqrt.sv
// Scoreboard bench for alt_isqrt: 16-bit unsigned, 16-bit signed and
// 5-bit unsigned instances share clock, reset, ena and out_ready.
module tb_alt_isqrt;

  logic        clock = 1'b0;
  logic        aclr_n, ena, out_ready;
  logic [15:0] data;
  logic [2:0]  iv, rdy, ov, ngv;
  logic [7:0]  root_u, root_s;
  logic [8:0]  rem_u, rem_s;
  logic [2:0]  root_5;
  logic [3:0]  rem_5;
  int          rt[3], rm[3];
  int          cyc = 0;
  int          errors = 0, checks = 0;

  typedef struct {int root; int rem; bit neg; int lat; int acc;} exp_t;
  exp_t sb[3][$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  alt_isqrt #(.data_width(16), .representation("UNSIGNED")) u_u (
    .clock(clock), .aclr_n(aclr_n), .ena(ena), .data(data), .in_valid(iv[0]),
    .in_ready(rdy[0]), .root(root_u), .remainder(rem_u), .neg(ngv[0]),
    .out_valid(ov[0]), .out_ready(out_ready));
  alt_isqrt #(.data_width(16), .representation("SIGNED")) u_s (
    .clock(clock), .aclr_n(aclr_n), .ena(ena), .data(data), .in_valid(iv[1]),
    .in_ready(rdy[1]), .root(root_s), .remainder(rem_s), .neg(ngv[1]),
    .out_valid(ov[1]), .out_ready(out_ready));
  alt_isqrt #(.data_width(5), .representation("UNSIGNED")) u_5 (
    .clock(clock), .aclr_n(aclr_n), .ena(ena), .data(data[4:0]), .in_valid(iv[2]),
    .in_ready(rdy[2]), .root(root_5), .remainder(rem_5), .neg(ngv[2]),
    .out_valid(ov[2]), .out_ready(out_ready));

  always_comb begin
    rt[0] = int'(root_u); rm[0] = int'(rem_u);
    rt[1] = int'(root_s); rm[1] = int'(rem_s);
    rt[2] = int'(root_5); rm[2] = int'(rem_5);
  end

  function automatic void check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference: largest r with r*r <= |x|, by plain search.
  function automatic exp_t model(input int inst, input logic [15:0] d, input int lat, input int acc);
    exp_t   e;
    longint mag;
    int     r;
    e.neg = 1'b0;
    case (inst)
      0:       mag = longint'(d);
      1: begin e.neg = d[15]; mag = d[15] ? 65536 - longint'(d) : longint'(d); end
      default: mag = longint'(d[4:0]);
    endcase
    r = 0;
    while (longint'(r + 1) * longint'(r + 1) <= mag) r++;
    e.root = r;
    e.rem  = int'(mag - longint'(r) * longint'(r));
    e.lat  = lat;
    e.acc  = acc;
    return e;
  endfunction

  task automatic send(input int inst, input logic [15:0] d, input int lat, input bit push);
    int n = 0;
    @(negedge clock);
    while (!rdy[inst] && n < 100) begin @(negedge clock); n++; end
    if (n >= 100) begin check(1'b0, "send_timeout", inst, 1); return; end
    data = d;
    iv[inst] = 1'b1;
    @(posedge clock); #1;
    iv = '0;
    if (push) sb[inst].push_back(model(inst, d, lat, cyc));
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clock);
    while ((sb[0].size() + sb[1].size() + sb[2].size() != 0 || ov != 0) && n < 300) begin
      @(negedge clock); n++;
    end
    if (n >= 300) check(1'b0, "drain_timeout", sb[0].size() + sb[1].size() + sb[2].size(), 0);
  endtask

  // Monitor: latency on out_valid rise, result compare on each transfer.
  logic [2:0] ovp = '0;
  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (ov[i] && !ovp[i] && sb[i].size() > 0 && sb[i][0].lat >= 0)
        check((cyc - sb[i][0].acc) == sb[i][0].lat, "latency", cyc - sb[i][0].acc, sb[i][0].lat);
      if (ov[i] && out_ready && ena) begin
        if (sb[i].size() == 0) check(1'b0, "unexpected_output", i, -1);
        else begin
          exp_t e;
          e = sb[i].pop_front();
          check(rt[i] == e.root, "root", rt[i], e.root);
          check(rm[i] == e.rem, "remainder", rm[i], e.rem);
          check(ngv[i] == e.neg, "neg", int'(ngv[i]), int'(e.neg));
        end
      end
      ovp[i] = ov[i];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got %0d cycles, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int vals[32];
    int n, r0, m0;
    aclr_n = 1'b0; ena = 1'b1; out_ready = 1'b1; iv = '0; data = '0;
    repeat (3) @(posedge clock); #1;
    check(ov == 3'b000, "reset_out_valid", int'(ov), 0);
    check(rt[0] == 0 && rm[0] == 0, "reset_root_rem", rt[0] + rm[0], 0);
    check(rdy == 3'b000, "reset_in_ready", int'(rdy), 0);
    aclr_n = 1'b1; #1;
    check(rdy == 3'b111, "in_ready_after_reset", int'(rdy), 7);

    // Directed unsigned / signed / odd-width values
    send(0, 16'd0, 8, 1);      drain();
    send(0, 16'd100, 8, 1);    drain();
    send(0, 16'd99, 8, 1);     drain();
    send(0, 16'd65535, 8, 1);  drain();
    send(1, 16'hFF9C, 8, 1);   drain();
    send(1, 16'h8000, 8, 1);   drain();
    send(1, 16'h0064, 8, 1);   drain();
    send(2, 16'd31, 3, 1);     drain();

    // Backpressure: result held 5 cycles with out_ready low
    out_ready = 1'b0;
    send(0, 16'd100, 8, 1);
    n = 0;
    while (!ov[0] && n < 50) begin @(negedge clock); n++; end
    check(n < 50, "bp_rise_timeout", n, 0);
    r0 = rt[0]; m0 = rm[0];
    for (int k = 0; k < 5; k++) begin
      check(ov[0] && rt[0] == r0 && rm[0] == m0, "bp_hold", rt[0], r0);
      check(rdy[0] == 1'b0, "bp_in_ready", int'(rdy[0]), 0);
      @(negedge clock);
    end
    @(posedge clock); #1 out_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check(rdy[0] == 1'b1 && ov[0] == 1'b0, "in_ready_after_xfer", int'(rdy[0]), 1);
    drain();

    // ena low for 3 cycles mid-BUSY stretches latency by 3
    send(0, 16'd1000, 11, 1);
    @(posedge clock); #1 ena = 1'b0;
    repeat (3) @(posedge clock);
    #1 ena = 1'b1;
    drain();

    // Reset during BUSY discards the operation
    send(0, 16'd1000, -1, 0);
    repeat (3) @(negedge clock);
    check(rdy[0] == 1'b0, "busy_in_ready", int'(rdy[0]), 0);
    aclr_n = 1'b0; #1;
    check(ov[0] == 1'b0, "reset_mid_out_valid", int'(ov[0]), 0);
    check(rdy[0] == 1'b0, "reset_mid_in_ready", int'(rdy[0]), 0);
    @(posedge clock); #1 aclr_n = 1'b1;
    send(0, 16'd49, 8, 1);     drain();

    // All 5-bit values in shuffled order
    for (int i = 0; i < 32; i++) vals[i] = i;
    for (int i = 31; i > 0; i--) begin
      int j, t;
      j = $urandom_range(i, 0);
      t = vals[i]; vals[i] = vals[j]; vals[j] = t;
    end
    for (int i = 0; i < 32; i++) begin send(2, 16'(vals[i]), 3, 1); drain(); end

    // Random 16-bit unsigned and signed
    for (int i = 0; i < 10; i++) begin send(0, 16'($urandom_range(65535, 0)), 8, 1); drain(); end
    for (int i = 0; i < 10; i++) begin send(1, 16'($urandom_range(65535, 0)), 8, 1); drain(); end

    repeat (5) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
